// File: rtl/i2c_lcd_master.sv
// i2c_lcd_master: I2C write master for the LCD I/O expander (START, addr+W, 1..MAX_BYTES bytes, STOP).
// Latency: (2 + 9*(1+n)) bit periods of 4*QDIV clocks, plus one accept clock and one done clock.
// Backpressure: start is ignored while busy and in the done cycle; slave SCL stretching only with I2C_CLK_STRETCH_EN.
//
// Ports: clk, rst_n (async, active low); start/byte_cnt/wr_data request (byte 0 = wr_data[7:0], MSB first);
//        busy/done/nack status (nack valid with done, held until next accepted start); scl/sda open drain (0 or Z).
// Optional feature macro: I2C_CLK_STRETCH_EN -- while SCL is released (Q2/Q3) and reads low, the quarter
//        divider is held at 0, so Q3 ends only after SCL has been high for a full quarter.
module i2c_lcd_master #(
  parameter int         CLK_HZ    = 50000000,
  parameter int         I2C_HZ    = 100000,
  parameter logic [6:0] DEV_ADDR  = 7'h27,
  parameter int         MAX_BYTES = 4,
  parameter int         CW        = $clog2(MAX_BYTES + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [CW-1:0]          byte_cnt,
  input  logic [8*MAX_BYTES-1:0] wr_data,
  output logic                   busy,
  output logic                   done,
  output logic                   nack,
  inout  wire                    scl,
  inout  wire                    sda
);

  localparam int QDIV = CLK_HZ / (4 * I2C_HZ);
  localparam int DW   = (QDIV > 1) ? $clog2(QDIV) : 1;
  localparam logic [DW-1:0] QMAX = DW'(QDIV - 1);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] START    = 3'd1;
  localparam logic [2:0] ADDR     = 3'd2;
  localparam logic [2:0] ADDR_ACK = 3'd3;
  localparam logic [2:0] DATA     = 3'd4;
  localparam logic [2:0] DATA_ACK = 3'd5;
  localparam logic [2:0] STOP     = 3'd6;
  localparam logic [2:0] DONE     = 3'd7;

  logic [2:0]             state;
  logic [DW-1:0]          div;
  logic [1:0]             q;
  logic [2:0]             bit_cnt;
  logic [CW-1:0]          byte_idx;
  logic [CW-1:0]          n_bytes;
  logic [8*MAX_BYTES-1:0] data_r;
  logic [7:0]             shreg;
  logic                   scl_oe;
  logic                   sda_oe;
  logic                   sda_in;
  logic                   hold;
  logic                   q_tick;
  logic                   cnt_ok;

  assign sda    = sda_oe ? 1'b0 : 1'bz;
  assign scl    = scl_oe ? 1'b0 : 1'bz;
  assign sda_in = sda;

`ifdef I2C_CLK_STRETCH_EN
  logic scl_in;
  assign scl_in = scl;
  // Q2/Q3 are the quarters where SCL is released; a low read there means the slave is stretching.
  // Holding the divider at 0 (rather than just pausing) guarantees a full high quarter afterwards.
  assign hold = q[1] && !scl_in;
`else
  assign hold = 1'b0;
`endif

  assign q_tick = (div == QMAX) && !hold;
  assign cnt_ok = (n_bytes != '0) && (n_bytes <= CW'(MAX_BYTES));
  assign busy   = (state != IDLE) && (state != DONE);
  assign done   = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      div      <= '0;
      q        <= '0;
      bit_cnt  <= '0;
      byte_idx <= '0;
      n_bytes  <= '0;
      data_r   <= '0;
      shreg    <= '0;
      nack     <= 1'b0;
    end else begin
      if (state == IDLE || state == DONE || hold || q_tick) begin
        div <= '0;
      end else begin
        div <= div + DW'(1);
      end

      case (state)
        IDLE: begin
          q <= '0;
          if (start) begin
            n_bytes  <= byte_cnt;
            data_r   <= wr_data;
            byte_idx <= '0;
            nack     <= 1'b0;
            state    <= START;
          end
        end
        DONE: state <= IDLE;
        default: begin
          if (q_tick) begin
            q <= q + 2'd1;
            // All state changes happen at the end of Q3, i.e. at bit boundaries.
            if (q == 2'd3) begin
              case (state)
                START: begin
                  shreg   <= {DEV_ADDR, 1'b0};
                  bit_cnt <= '0;
                  state   <= ADDR;
                end
                ADDR, DATA: begin
                  shreg   <= {shreg[6:0], 1'b0};
                  bit_cnt <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) begin
                    state <= (state == ADDR) ? ADDR_ACK : DATA_ACK;
                  end
                end
                ADDR_ACK: begin
                  if (sda_in) begin
                    nack  <= 1'b1;
                    state <= STOP;
                  end else if (cnt_ok) begin
                    shreg   <= data_r[7:0];
                    data_r  <= data_r >> 8;
                    bit_cnt <= '0;
                    state   <= DATA;
                  end else begin
                    state <= STOP;
                  end
                end
                DATA_ACK: begin
                  if (sda_in) begin
                    nack  <= 1'b1;
                    state <= STOP;
                  end else if (byte_idx + CW'(1) == n_bytes) begin
                    state <= STOP;
                  end else begin
                    byte_idx <= byte_idx + CW'(1);
                    shreg    <= data_r[7:0];
                    data_r   <= data_r >> 8;
                    bit_cnt  <= '0;
                    state    <= DATA;
                  end
                end
                STOP:    state <= DONE;
                default: state <= IDLE;
              endcase
            end
          end
        end
      endcase
    end
  end

  // Line drive per quarter. Data bits hold SDA for the whole bit; SCL is low in Q0/Q1.
  always_comb begin
    scl_oe = 1'b0;
    sda_oe = 1'b0;
    case (state)
      START: sda_oe = q[1];
      ADDR, DATA: begin
        scl_oe = !q[1];
        sda_oe = !shreg[7];
      end
      ADDR_ACK, DATA_ACK: scl_oe = !q[1];
      STOP: begin
        scl_oe = (q == 2'd0);
        sda_oe = (q != 2'd3);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_i2c_lcd_master.sv
// tb_i2c_lcd_master: directed bench for i2c_lcd_master with QDIV=1 (4 clocks per SCL bit).
// A polled bus monitor/slave samples the pulled-up lines 1ns after each clock edge, decodes
// START/STOP/bytes, drives ACK/NACK and optionally stretches SCL on a chosen ACK slot.
module tb_i2c_lcd_master;

  localparam int CW = 3;
  localparam int MB = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic [CW-1:0]   byte_cnt = '0;
  logic [8*MB-1:0] wr_data = '0;
  logic            busy, done, nack;
  wire             scl_w, sda_w;

  int n_tests = 0;
  int n_fail  = 0;

  // slave / monitor state
  logic        sl_sda = 1'b0;
  logic        sl_scl = 1'b0;
  int          hold_cnt = 0;
  int          nack_at = -1;
  int          stretch_slot = -1;
  logic        p_scl = 1'b1, p_sda = 1'b1, s_scl, s_sda;
  int          bit_n = 0, slot_n = 0;
  logic [7:0]  cur = '0;
  logic [63:0] rx_cat = '0;
  logic [7:0]  ack_cat = '0;
  int          rx_n = 0, n_start = 0, n_stop = 0;

  assign sda_w = sl_sda ? 1'b0 : 1'bz;
  assign scl_w = sl_scl ? 1'b0 : 1'bz;
  pullup (sda_w);
  pullup (scl_w);

  always #5 clk = ~clk;

  i2c_lcd_master #(
    .CLK_HZ(400000), .I2C_HZ(100000), .DEV_ADDR(7'h27), .MAX_BYTES(MB), .CW(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .byte_cnt(byte_cnt), .wr_data(wr_data),
    .busy(busy), .done(done), .nack(nack), .scl(scl_w), .sda(sda_w)
  );

  always @(posedge clk) begin
    #1;
    s_scl = scl_w;
    s_sda = sda_w;
    if (hold_cnt > 0) begin
      hold_cnt = hold_cnt - 1;
      if (hold_cnt == 0) sl_scl = 1'b0;
    end
    if (p_scl && s_scl && p_sda && !s_sda) begin
      n_start++;
      bit_n  = 0;
      slot_n = 0;
    end else if (p_scl && s_scl && !p_sda && s_sda) begin
      n_stop++;
      bit_n = 0;
    end else if (!p_scl && s_scl) begin
      if (bit_n < 8) begin
        cur = {cur[6:0], s_sda};
      end else begin
        rx_cat  = {rx_cat[55:0], cur};
        ack_cat = {ack_cat[6:0], s_sda};
        rx_n++;
        slot_n++;
      end
      bit_n++;
    end else if (p_scl && !s_scl) begin
      if (bit_n == 8) begin
        sl_sda = (slot_n != nack_at);
        // 12 sampled cycles from the fall = 10 cycles past the master's release at Q2
        if (slot_n == stretch_slot) begin
          sl_scl   = 1'b1;
          hold_cnt = 12;
        end
      end else if (bit_n == 9) begin
        sl_sda = 1'b0;
        bit_n  = 0;
      end
    end
    p_scl = s_scl;
    p_sda = s_sda;
  end

  task automatic clear_mon();
    rx_cat = '0; ack_cat = '0; rx_n = 0; n_start = 0; n_stop = 0;
  endtask

  // Runs one transaction; cyc = edges from the accepting edge (1) to done seen, -1 on timeout.
  task automatic do_txn(input logic [CW-1:0] n, input logic [8*MB-1:0] d,
                        output int cyc, output logic b1, output logic nk1, output logic bz);
    clear_mon();
    @(posedge clk); #2;
    byte_cnt = n; wr_data = d; start = 1'b1;
    cyc = -1; b1 = 1'bx; nk1 = 1'bx; bz = 1'bx;
    for (int i = 1; i <= 1000; i++) begin
      @(posedge clk); #2;
      start = 1'b0;
      if (i == 1) begin b1 = busy; nk1 = nack; end
      if (done) begin cyc = i; bz = busy; break; end
    end
  endtask

  task automatic test_reset();
    #3;
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
    n_tests++; if (nack !== 1'b0) begin n_fail++; $display("FAIL reset_nack: got %b expected 0", nack); end
    n_tests++; if (scl_w !== 1'b1 || sda_w !== 1'b1) begin
      n_fail++; $display("FAIL reset_lines: got scl=%b sda=%b expected 1/1", scl_w, sda_w);
    end
    @(posedge clk); #2; rst_n = 1'b1;
    repeat (3) @(posedge clk);
  endtask

  task automatic test_single_byte();
    int cyc; logic b1, nk1, bz;
    do_txn(3'd1, 32'h0000_000C, cyc, b1, nk1, bz);
    n_tests++; if (cyc != 81) begin n_fail++; $display("FAIL single_len: got %0d expected 81", cyc); end
    n_tests++; if (b1 !== 1'b1) begin n_fail++; $display("FAIL single_busy1: got %b expected 1", b1); end
    n_tests++; if (bz !== 1'b0) begin n_fail++; $display("FAIL single_busy_at_done: got %b expected 0", bz); end
    n_tests++; if (rx_n != 2 || rx_cat !== 64'h4E0C) begin
      n_fail++; $display("FAIL single_bytes: got n=%0d %h expected n=2 4e0c", rx_n, rx_cat);
    end
    n_tests++; if (ack_cat !== 8'h00 || nack !== 1'b0) begin
      n_fail++; $display("FAIL single_ack: got acks=%b nack=%b expected 0/0", ack_cat, nack);
    end
    n_tests++; if (n_start != 1 || n_stop != 1) begin
      n_fail++; $display("FAIL single_start_stop: got %0d/%0d expected 1/1", n_start, n_stop);
    end
  endtask

  task automatic test_burst();
    int cyc; logic b1, nk1, bz;
    do_txn(3'd4, 32'h080C_283C, cyc, b1, nk1, bz);
    n_tests++; if (cyc != 189) begin n_fail++; $display("FAIL burst_len: got %0d expected 189", cyc); end
    n_tests++; if (rx_n != 5 || rx_cat !== 64'h4E3C_280C_08) begin
      n_fail++; $display("FAIL burst_bytes: got n=%0d %h expected n=5 4e3c280c08", rx_n, rx_cat);
    end
    n_tests++; if (ack_cat !== 8'h00 || nack !== 1'b0) begin
      n_fail++; $display("FAIL burst_ack: got acks=%b nack=%b expected 0/0", ack_cat, nack);
    end
  endtask

  task automatic test_addr_nack();
    int cyc; logic b1, nk1, bz;
    nack_at = 0;
    do_txn(3'd2, 32'h0000_5511, cyc, b1, nk1, bz);
    nack_at = -1;
    n_tests++; if (cyc != 45) begin n_fail++; $display("FAIL addr_nack_len: got %0d expected 45", cyc); end
    n_tests++; if (rx_n != 1 || rx_cat !== 64'h4E || ack_cat !== 8'h01) begin
      n_fail++; $display("FAIL addr_nack_bytes: got n=%0d %h acks=%b expected n=1 4e acks=1", rx_n, rx_cat, ack_cat);
    end
    n_tests++; if (nack !== 1'b1) begin n_fail++; $display("FAIL addr_nack_flag: got %b expected 1", nack); end
    n_tests++; if (n_stop != 1) begin n_fail++; $display("FAIL addr_nack_stop: got %0d expected 1", n_stop); end
    repeat (5) @(posedge clk); #2;
    n_tests++; if (nack !== 1'b1) begin n_fail++; $display("FAIL nack_hold: got %b expected 1", nack); end
  endtask

  task automatic test_data_nack();
    int cyc; logic b1, nk1, bz;
    nack_at = 2;
    do_txn(3'd3, 32'h00AA_55F0, cyc, b1, nk1, bz);
    nack_at = -1;
    n_tests++; if (nk1 !== 1'b0) begin n_fail++; $display("FAIL nack_clear_on_start: got %b expected 0", nk1); end
    n_tests++; if (cyc != 117) begin n_fail++; $display("FAIL data_nack_len: got %0d expected 117", cyc); end
    n_tests++; if (rx_n != 3 || rx_cat !== 64'h4EF055 || ack_cat !== 8'h01) begin
      n_fail++; $display("FAIL data_nack_bytes: got n=%0d %h acks=%b expected n=3 4ef055 acks=001", rx_n, rx_cat, ack_cat);
    end
    n_tests++; if (nack !== 1'b1) begin n_fail++; $display("FAIL data_nack_flag: got %b expected 1", nack); end
  endtask

  task automatic test_bad_count();
    int cyc; logic b1, nk1, bz;
    for (int k = 0; k < 2; k++) begin
      do_txn((k == 0) ? 3'd0 : 3'd5, 32'h1234_5678, cyc, b1, nk1, bz);
      n_tests++; if (cyc != 45 || rx_n != 1 || rx_cat !== 64'h4E || nack !== 1'b0) begin
        n_fail++; $display("FAIL bad_count_%0d: got len=%0d n=%0d %h nack=%b expected 45/1/4e/0", k, cyc, rx_n, rx_cat, nack);
      end
    end
  endtask

  task automatic test_back_to_back();
    int first, second; logic bi;
    clear_mon();
    @(posedge clk); #2;
    byte_cnt = 3'd1; wr_data = 32'h0000_000C; start = 1'b1;
    first = -1; second = -1;
    for (int i = 1; i <= 400; i++) begin
      @(posedge clk); #2;
      if (done) begin first = i; break; end
    end
    @(posedge clk); #2;
    bi = busy;
    for (int i = 1; i <= 400; i++) begin
      @(posedge clk); #2;
      if (done) begin second = i; break; end
    end
    start = 1'b0;
    n_tests++; if (first != 81) begin n_fail++; $display("FAIL b2b_first_len: got %0d expected 81", first); end
    n_tests++; if (bi !== 1'b0) begin n_fail++; $display("FAIL b2b_start_at_done: got busy=%b expected 0", bi); end
    n_tests++; if (second != 81) begin n_fail++; $display("FAIL b2b_second_len: got %0d expected 81", second); end
    n_tests++; if (rx_n != 4 || rx_cat !== 64'h4E0C_4E0C) begin
      n_fail++; $display("FAIL b2b_bytes: got n=%0d %h expected n=4 4e0c4e0c", rx_n, rx_cat);
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic test_reset_mid();
    int cyc; logic b1, nk1, bz, bb;
    clear_mon();
    @(posedge clk); #2;
    byte_cnt = 3'd2; wr_data = 32'h0000_FFFF; start = 1'b1;
    @(posedge clk); #2; start = 1'b0;
    repeat (49) @(posedge clk);
    #3; bb = busy;
    rst_n = 1'b0;
    #1;
    n_tests++; if (bb !== 1'b1) begin n_fail++; $display("FAIL mid_was_busy: got %b expected 1", bb); end
    n_tests++; if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL mid_rst_status: got busy=%b done=%b expected 0/0", busy, done);
    end
    n_tests++; if (scl_w !== 1'b1 || sda_w !== 1'b1) begin
      n_fail++; $display("FAIL mid_rst_lines: got scl=%b sda=%b expected 1/1", scl_w, sda_w);
    end
    @(posedge clk); #2; rst_n = 1'b1;
    repeat (3) @(posedge clk);
    do_txn(3'd1, 32'h0000_000C, cyc, b1, nk1, bz);
    n_tests++; if (cyc != 81 || rx_cat !== 64'h4E0C || nack !== 1'b0) begin
      n_fail++; $display("FAIL after_rst_txn: got len=%0d %h nack=%b expected 81/4e0c/0", cyc, rx_cat, nack);
    end
  endtask

  task automatic test_stretch();
    int cyc; logic b1, nk1, bz;
    stretch_slot = 0;
    do_txn(3'd1, 32'h0000_000C, cyc, b1, nk1, bz);
    stretch_slot = -1;
`ifdef I2C_CLK_STRETCH_EN
    n_tests++; if (cyc != 91) begin n_fail++; $display("FAIL stretch_len: got %0d expected 91", cyc); end
    n_tests++; if (rx_cat !== 64'h4E0C || nack !== 1'b0) begin
      n_fail++; $display("FAIL stretch_data: got %h nack=%b expected 4e0c/0", rx_cat, nack);
    end
`else
    n_tests++; if (cyc != 81) begin n_fail++; $display("FAIL no_stretch_len: got %0d expected 81", cyc); end
`endif
    sl_sda = 1'b0; sl_scl = 1'b0; hold_cnt = 0;
    repeat (3) @(posedge clk);
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_burst();
    test_addr_nack();
    test_data_nack();
    test_bad_count();
    test_back_to_back();
    test_reset_mid();
    test_stretch();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
